regfile_write_scheduler: RTL and testbench

- Owns the register-file write port and sequences it between the in-order pipeline writeback and one long-latency (multi-cycle) execution unit, such as a divider or a non-blocking load.
- Tracks destination registers with outstanding multi-cycle writes in a pending table and stalls decode on RAW/WAW hazards against them.
- Holds a multi-cycle result in a one-entry buffer while writeback owns the port.
- Sits beside the decode stage and drives the register file's a3/we3/wd3 inputs.

---
 rtl/regfile_write_scheduler_pkg.sv | 20 ++
 rtl/regfile_write_scheduler_if.sv | 41 ++++
 rtl/regfile_write_scheduler_pending.sv | 40 ++++
 rtl/regfile_write_scheduler.sv | 122 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, buffer state and write-source encodings for the register-file write scheduler.
package rf_sched_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_BUF,
        SRC_MC
    } wr_src_e;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Decode, writeback, multi-cycle result and register-file port signals of the write scheduler.
// Signal names keep their direction prefix as seen from the scheduler (slave side).
interface regfile_write_scheduler_if;
    import rf_sched_pkg::*;

    logic                  i_d_valid;
    logic [REG_ADDR_W-1:0] i_d_rs1;
    logic [REG_ADDR_W-1:0] i_d_rs2;
    logic [REG_ADDR_W-1:0] i_d_rd;
    logic                  i_d_issue_mc;
    logic                  o_d_stall;

    logic                  i_w_we;
    logic [REG_ADDR_W-1:0] i_w_rd;
    logic [XLEN-1:0]       i_w_result;

    logic                  i_mc_valid;
    logic [REG_ADDR_W-1:0] i_mc_rd;
    logic [XLEN-1:0]       i_mc_result;
    logic                  o_mc_ready;

    logic                  o_rf_we;
    logic [REG_ADDR_W-1:0] o_rf_addr;
    logic [XLEN-1:0]       o_rf_wd;
    logic                  o_starve_stall;

    modport master (
        output i_d_valid, i_d_rs1, i_d_rs2, i_d_rd, i_d_issue_mc,
        output i_w_we, i_w_rd, i_w_result,
        output i_mc_valid, i_mc_rd, i_mc_result,
        input  o_d_stall, o_mc_ready, o_rf_we, o_rf_addr, o_rf_wd, o_starve_stall
    );

    modport slave (
        input  i_d_valid, i_d_rs1, i_d_rs2, i_d_rd, i_d_issue_mc,
        input  i_w_we, i_w_rd, i_w_result,
        input  i_mc_valid, i_mc_rd, i_mc_result,
        output o_d_stall, o_mc_ready, o_rf_we, o_rf_addr, o_rf_wd, o_starve_stall
    );

endinterface

// File: rtl/regfile_write_scheduler_pending.sv
// rf_pending_table: bitmap of registers awaiting a multi-cycle write, with three read ports.
// Bit 0 is forced to zero; a same-cycle set and clear of one bit resolves to set.
module rf_pending_table
    import rf_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr0,
    input  logic [REG_ADDR_W-1:0] i_rd_addr1,
    input  logic [REG_ADDR_W-1:0] i_rd_addr2,
    output logic                  o_rd_bit0,
    output logic                  o_rd_bit1,
    output logic                  o_rd_bit2
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        pend_d = pend_q;
        if (i_clr_en) pend_d[i_clr_addr] = 1'b0;
        if (i_set_en) pend_d[i_set_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign o_rd_bit0 = pend_q[i_rd_addr0];
    assign o_rd_bit1 = pend_q[i_rd_addr1];
    assign o_rd_bit2 = pend_q[i_rd_addr2];

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: writeback > hold buffer > multi-cycle result, with hazard stalls.
// RF_SCHED_DIRECT_EN enables the zero-latency direct path; otherwise every result passes the buffer.
module regfile_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int MC_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                      i_clk,
    input logic                      i_rst,
    regfile_write_scheduler_if.slave bus
);

    localparam int CNT_W = $clog2(MC_DEPTH + 1);

    buf_state_e            state_q;
    logic [REG_ADDR_W-1:0] buf_rd_q;
    logic [XLEN-1:0]       buf_data_q;
    logic [CNT_W-1:0]      mc_cnt_q;
    logic [3:0]            starve_q;

    wr_src_e               src;
    logic [REG_ADDR_W-1:0] rf_addr;
    logic [XLEN-1:0]       rf_wd;
    logic pend_rs1, pend_rs2, pend_rd;
    logic wb_busy, mc_full, d_stall, issue, mc_ready, mc_accept, capture, mc_write;

    // Writeback owns the port whenever it asserts i_w_we, even for x0.
    assign wb_busy   = bus.i_w_we;
    assign mc_full   = (mc_cnt_q == CNT_W'(MC_DEPTH));
    assign d_stall   = ~i_rst & bus.i_d_valid
                     & (pend_rs1 | pend_rs2 | (bus.i_d_issue_mc & (pend_rd | mc_full)));
    assign issue     = ~i_rst & bus.i_d_valid & bus.i_d_issue_mc & ~d_stall;
    assign mc_ready  = ~i_rst & (state_q == BUF_EMPTY);
    assign mc_accept = bus.i_mc_valid & mc_ready;

`ifdef RF_SCHED_DIRECT_EN
    assign capture = mc_accept & wb_busy & (bus.i_mc_rd != '0);
`else
    assign capture = mc_accept & (bus.i_mc_rd != '0);
`endif

    always_comb begin
        src     = SRC_NONE;
        rf_addr = '0;
        rf_wd   = '0;
        if (wb_busy) begin
            src     = SRC_WB;
            rf_addr = bus.i_w_rd;
            rf_wd   = bus.i_w_result;
        end else if (state_q == BUF_FULL) begin
            src     = SRC_BUF;
            rf_addr = buf_rd_q;
            rf_wd   = buf_data_q;
        end
`ifdef RF_SCHED_DIRECT_EN
        else if (mc_accept) begin
            src     = SRC_MC;
            rf_addr = bus.i_mc_rd;
            rf_wd   = bus.i_mc_result;
        end
`endif
    end

    assign mc_write = ~i_rst & ((src == SRC_BUF) | (src == SRC_MC)) & (rf_addr != '0);

    rf_pending_table u_pending (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (issue & (bus.i_d_rd != '0)),
        .i_set_addr (bus.i_d_rd),
        .i_clr_en   (mc_write),
        .i_clr_addr (rf_addr),
        .i_rd_addr0 (bus.i_d_rs1),
        .i_rd_addr1 (bus.i_d_rs2),
        .i_rd_addr2 (bus.i_d_rd),
        .o_rd_bit0  (pend_rs1),
        .o_rd_bit1  (pend_rs2),
        .o_rd_bit2  (pend_rd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= BUF_EMPTY;
            mc_cnt_q <= '0;
            starve_q <= '0;
        end else begin
            if (issue && !mc_accept)      mc_cnt_q <= mc_cnt_q + CNT_W'(1);
            else if (mc_accept && !issue) mc_cnt_q <= mc_cnt_q - CNT_W'(1);

            case (state_q)
                BUF_EMPTY: if (capture) state_q <= BUF_FULL;
                BUF_FULL: begin
                    if (!wb_busy) begin
                        state_q  <= BUF_EMPTY;
                        starve_q <= '0;
                    end else if (starve_q != 4'(STARVE_LIMIT)) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    // NOTE: the payload carries no reset; it is only read while state_q is BUF_FULL.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            buf_rd_q   <= bus.i_mc_rd;
            buf_data_q <= bus.i_mc_result;
        end
    end

    assign bus.o_d_stall      = d_stall;
    assign bus.o_mc_ready     = mc_ready;
    assign bus.o_rf_we        = ~i_rst & (src != SRC_NONE) & (rf_addr != '0);
    assign bus.o_rf_addr      = rf_addr;
    assign bus.o_rf_wd        = rf_wd;
    assign bus.o_starve_stall = ~i_rst & (starve_q == 4'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the scheduling rules.
module tb_regfile_write_scheduler;
    import rf_sched_pkg::*;

    localparam int MC_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef RF_SCHED_DIRECT_EN
    localparam bit DIRECT = 1'b1;
`else
    localparam bit DIRECT = 1'b0;
`endif

    typedef struct {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_scheduler_if bus ();

    regfile_write_scheduler #(
        .MC_DEPTH     (MC_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: results in flight in the unit, results parked in the buffer, pending registers.
    res_t inflight[$];
    res_t hold[$];
    bit   pend[NUM_REGS];
    int   waited = 0;

    logic [XLEN-1:0]       issue_data;
    bit                    e_stall, e_ready, e_starve, e_we, e_issue, e_accept, wr_hold, wr_direct;
    logic [REG_ADDR_W-1:0] e_addr;
    logic [XLEN-1:0]       e_data;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dec(input bit v, input int rs1, input int rs2, input int rd, input bit mc);
        bus.i_d_valid    = v;
        bus.i_d_rs1      = REG_ADDR_W'(rs1);
        bus.i_d_rs2      = REG_ADDR_W'(rs2);
        bus.i_d_rd       = REG_ADDR_W'(rd);
        bus.i_d_issue_mc = mc;
    endtask

    task automatic wb(input bit we, input int rd, input logic [XLEN-1:0] data);
        bus.i_w_we     = we;
        bus.i_w_rd     = REG_ADDR_W'(rd);
        bus.i_w_result = data;
    endtask

    task automatic drive_mc(input bit en);
        if (en && inflight.size() != 0) begin
            bus.i_mc_valid  = 1'b1;
            bus.i_mc_rd     = inflight[0].rd;
            bus.i_mc_result = inflight[0].data;
        end else begin
            bus.i_mc_valid  = 1'b0;
            bus.i_mc_rd     = '0;
            bus.i_mc_result = '0;
        end
    endtask

    // Predict and compare outputs mid-cycle, with inputs stable.
    task automatic settle();
        @(negedge clk);
        e_stall = 0; e_ready = 0; e_starve = 0; e_we = 0; e_issue = 0; e_accept = 0;
        wr_hold = 0; wr_direct = 0; e_addr = '0; e_data = '0;
        if (!rst) begin
            e_ready  = (hold.size() == 0);
            e_accept = bus.i_mc_valid && e_ready;
            e_stall  = bus.i_d_valid && (pend[bus.i_d_rs1] || pend[bus.i_d_rs2] ||
                       (bus.i_d_issue_mc && (pend[bus.i_d_rd] || inflight.size() == MC_DEPTH)));
            e_issue  = bus.i_d_valid && bus.i_d_issue_mc && !e_stall;
            if (bus.i_w_we) begin
                e_we = (bus.i_w_rd != 0); e_addr = bus.i_w_rd; e_data = bus.i_w_result;
            end else if (hold.size() != 0) begin
                wr_hold = 1; e_we = 1; e_addr = hold[0].rd; e_data = hold[0].data;
            end else if (DIRECT && e_accept) begin
                wr_direct = 1; e_we = (bus.i_mc_rd != 0); e_addr = bus.i_mc_rd; e_data = bus.i_mc_result;
            end
            e_starve = (hold.size() != 0) && (waited >= STARVE_LIMIT);
        end
        check("d_stall", bus.o_d_stall, e_stall);
        check("mc_ready", bus.o_mc_ready, e_ready);
        check("starve_stall", bus.o_starve_stall, e_starve);
        check("rf_we", bus.o_rf_we, e_we);
        if (e_we) begin
            check("rf_addr", bus.o_rf_addr, e_addr);
            check("rf_wd", bus.o_rf_wd, e_data);
        end
    endtask

    task automatic advance();
        res_t r;
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            hold.delete();
            foreach (pend[i]) pend[i] = 0;
            waited = 0;
        end else begin
            if (wr_hold) begin
                r = hold.pop_front();
                pend[r.rd] = 0;
                waited = 0;
            end else if (hold.size() != 0 && bus.i_w_we) begin
                waited++;
            end
            if (e_accept) begin
                r = inflight.pop_front();
                if (r.rd != 0) begin
                    if (wr_direct) pend[r.rd] = 0;
                    else begin hold.push_back(r); waited = 0; end
                end
            end
            if (e_issue) begin
                r.rd = bus.i_d_rd;
                r.data = issue_data;
                inflight.push_back(r);
                if (r.rd != 0) pend[r.rd] = 1;
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic drain();
        dec(0, 0, 0, 0, 0);
        wb(0, 0, '0);
        for (int i = 0; i < 40 && (inflight.size() != 0 || hold.size() != 0); i++) begin
            drive_mc(1);
            cyc();
        end
        drive_mc(0);
        settle();
        check("drain_ready", bus.o_mc_ready, 1);
        advance();
    endtask

    initial begin
        dec(0, 0, 0, 0, 0);
        wb(0, 0, '0);
        drive_mc(0);
        issue_data = '0;
        foreach (pend[i]) pend[i] = 0;

        // Reset: outputs held low even with requests present.
        rst = 1'b1;
        cyc();
        wb(1, 3, 32'h1234_5678);
        dec(1, 0, 0, 4, 1);
        settle();
        check("rst_we", bus.o_rf_we, 0);
        check("rst_ready", bus.o_mc_ready, 0);
        check("rst_stall", bus.o_d_stall, 0);
        advance();
        rst = 1'b0;
        wb(0, 0, '0);

        // RAW on a pending multi-cycle destination.
        issue_data = 32'h0000_5555;
        dec(1, 0, 0, 5, 1); cyc();
        dec(1, 5, 0, 0, 0);
        settle(); check("raw_stall", bus.o_d_stall, 1); advance();
        drive_mc(1);
        settle(); check("raw_stall_ret", bus.o_d_stall, 1); check("direct_we", bus.o_rf_we, DIRECT); advance();
        drive_mc(0);
        settle(); check("raw_stall_next", bus.o_d_stall, !DIRECT); advance();
        cyc();
        dec(0, 0, 0, 0, 0);

        // Result collides with writeback: buffered, then written on the idle cycle.
        issue_data = 32'hDEAD_BEEF;
        dec(1, 0, 0, 7, 1); cyc();
        dec(0, 0, 0, 0, 0);
        wb(1, 3, 32'h3333_3333); drive_mc(1);
        settle();
        check("wb_first_addr", bus.o_rf_addr, 3);
        check("wb_first_data", bus.o_rf_wd, 32'h3333_3333);
        check("wb_first_ready", bus.o_mc_ready, 1);
        advance();
        wb(0, 0, '0); drive_mc(0);
        settle();
        check("buf_ready", bus.o_mc_ready, 0);
        check("buf_addr", bus.o_rf_addr, 7);
        check("buf_data", bus.o_rf_wd, 32'hDEAD_BEEF);
        advance();
        settle(); check("buf_ready_after", bus.o_mc_ready, 1); advance();

        // Starvation: writeback held busy while the buffer is full.
        issue_data = $urandom;
        dec(1, 0, 0, 9, 1); cyc();
        dec(0, 0, 0, 0, 0);
        wb(1, 4, $urandom); drive_mc(1); cyc();
        drive_mc(0);
        for (int k = 1; k <= STARVE_LIMIT + 2; k++) begin
            settle(); check("starve_hold", bus.o_starve_stall, (k > STARVE_LIMIT)); advance();
        end
        wb(0, 0, '0);
        settle(); check("starve_drain", bus.o_starve_stall, 1); check("starve_addr", bus.o_rf_addr, 9); advance();
        settle(); check("starve_clear", bus.o_starve_stall, 0); advance();

        // Outstanding limit.
        issue_data = $urandom; dec(1, 0, 0, 10, 1); cyc();
        issue_data = $urandom; dec(1, 0, 0, 11, 1); cyc();
        issue_data = $urandom; dec(1, 0, 0, 12, 1);
        settle(); check("depth_stall", bus.o_d_stall, 1); advance();
        drive_mc(1);
        settle(); check("depth_stall_acc", bus.o_d_stall, 1); check("depth_ready", bus.o_mc_ready, 1); advance();
        drive_mc(0);
        settle(); check("depth_stall_clear", bus.o_d_stall, 0); advance();
        drain();

        // x0 destinations: handshake completes, nothing written, nothing pending.
        issue_data = $urandom;
        dec(1, 0, 0, 0, 1); cyc();
        dec(1, 0, 0, 0, 0);
        wb(1, 0, $urandom); drive_mc(1);
        settle(); check("x0_we", bus.o_rf_we, 0); check("x0_ready", bus.o_mc_ready, 1); advance();
        wb(0, 0, '0); drive_mc(0);
        settle(); check("x0_ready_after", bus.o_mc_ready, 1); check("x0_stall", bus.o_d_stall, 0); advance();

        // Reset with the buffer full and registers pending.
        dec(1, 0, 0, 13, 1); issue_data = $urandom; cyc();
        dec(1, 0, 0, 14, 1); issue_data = $urandom; cyc();
        dec(0, 0, 0, 0, 0);
        wb(1, 2, $urandom); drive_mc(1); cyc();
        drive_mc(0);
        settle(); check("pre_rst_ready", bus.o_mc_ready, 0); advance();
        rst = 1'b1;
        settle(); check("mid_rst_we", bus.o_rf_we, 0); check("mid_rst_starve", bus.o_starve_stall, 0); advance();
        rst = 1'b0;
        wb(0, 0, '0); dec(1, 14, 13, 0, 0);
        settle(); check("post_rst_stall", bus.o_d_stall, 0); check("post_rst_ready", bus.o_mc_ready, 1); advance();

        // Random traffic with bursty writeback to exercise buffering and starvation.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (!e_stall || rst)
                dec($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 9) < 4);
            wb($urandom_range(0, 99) < ((n % 100) < 50 ? 85 : 30), $urandom_range(0, 7), $urandom);
            issue_data = $urandom;
            drive_mc($urandom_range(0, 1) == 1);
            cyc();
        end
        rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
